// File: rtl/memctrl_host_if.sv
// Valid/ready to MEMCTRL SRAM-pin bridge: one access + one recovery cycle per beat.
// Optional read bursts (req_len+1 beats) are enabled with `define MEMHOST_BURST_EN.
module memctrl_host_if #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
`ifdef MEMHOST_BURST_EN
    input  logic [7:0]    req_len,
`endif
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,
    output logic [AW-1:0] ADDR,
    output logic          CE,
    output logic          CSB,
    output logic          WEB,
    output logic          OEB,
    output logic [DW-1:0] IDATA,
    input  logic [DW-1:0] ODATA
);

    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RECOVER,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state;
    logic          cur_we;
    logic [CW-1:0] wait_cnt;
    logic          more_beats;

`ifdef MEMHOST_BURST_EN
    logic [7:0] beats_left;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            beats_left <= 8'd0;
        end else if (state == ST_IDLE && req_valid) begin
            beats_left <= req_we ? 8'd0 : req_len;
        end else if (state == ST_RESP && rsp_ready && more_beats) begin
            beats_left <= beats_left - 8'd1;
        end
    end

    assign more_beats = !cur_we && (beats_left != 8'd0);
`else
    assign more_beats = 1'b0;
`endif

    // Single-process FSM; every pin and response field is a register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            cur_we    <= 1'b0;
            wait_cnt  <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
            ADDR      <= '0;
            CE        <= 1'b0;
            CSB       <= 1'b1;
            WEB       <= 1'b1;
            OEB       <= 1'b1;
            IDATA     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state     <= ST_ACCESS;
                        cur_we    <= req_we;
                        req_ready <= 1'b0;
                        ADDR      <= req_addr;
                        CE        <= 1'b1;
                        CSB       <= 1'b0;
                        WEB       <= !req_we;
                        OEB       <= req_we;
                        IDATA     <= req_we ? req_wdata : '0;
                    end
                end
                ST_ACCESS: begin
                    state    <= ST_RECOVER;
                    CE       <= 1'b0;
                    CSB      <= 1'b1;
                    WEB      <= 1'b1;
                    IDATA    <= '0;
                    wait_cnt <= '0;
                    if (cur_we) begin
                        OEB <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (cur_we) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_last  <= !more_beats;
                    end else if (RD_LAT == 1) begin
                        state     <= ST_RESP;
                        OEB       <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b0;
                        rsp_rdata <= ODATA;
                        rsp_last  <= !more_beats;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= CW'(RD_LAT - 32'd2);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_RESP;
                        OEB       <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b0;
                        rsp_rdata <= ODATA;
                        rsp_last  <= !more_beats;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (more_beats) begin
                            // Next burst beat goes straight back out; address wraps naturally.
                            state <= ST_ACCESS;
                            ADDR  <= ADDR + AW'(1);
                            CE    <= 1'b1;
                            CSB   <= 1'b0;
                            WEB   <= 1'b1;
                            OEB   <= 1'b0;
                            IDATA <= '0;
                        end else begin
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memctrl_host_if.sv
// Directed bench for memctrl_host_if with a small synchronous SRAM model on the pins.
// Define MEMHOST_BURST_EN for both files to exercise the wrapping read burst.
module tb_memctrl_host_if;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [7:0]  rsp_rdata;
    logic        rsp_last;
    logic [15:0] ADDR;
    logic        CE;
    logic        CSB;
    logic        WEB;
    logic        OEB;
    logic [7:0]  IDATA;
    logic [7:0]  ODATA;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem [0:65535];

    always #5 CLK = ~CLK;

    memctrl_host_if dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef MEMHOST_BURST_EN
        .req_len   (req_len),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .ADDR      (ADDR),
        .CE        (CE),
        .CSB       (CSB),
        .WEB       (WEB),
        .OEB       (OEB),
        .IDATA     (IDATA),
        .ODATA     (ODATA)
    );

    // SRAM model: registers the selected access on the edge ending the access cycle.
    always @(posedge CLK) begin
        if (CE && !CSB) begin
            if (!WEB) mem[ADDR] <= IDATA;
            else      ODATA     <= mem[ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One single-beat request; stall = cycles rsp_ready is held low once rsp_valid shows.
    task automatic run_req(input string tag, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rdata, input int stall);
        int cyc, ce_n, oeb_n, web_n, rsp_cyc;
        logic seen, stable;
        logic [15:0] acc_addr;
        logic [7:0]  acc_idata, got_rdata;
        logic        got_we, got_last;
        ce_n = 0; oeb_n = 0; web_n = 0; rsp_cyc = 0; seen = 1'b0; stable = 1'b1;
        got_rdata = '0; got_we = 1'b0; got_last = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_len = 8'd0;
        rsp_ready = (stall == 0);
        tick();
        req_valid = 1'b0;
        cyc = 1;
        acc_addr  = ADDR;
        acc_idata = IDATA;
        while (!seen && cyc <= 20) begin
            if (CE)   ce_n++;
            if (!OEB) oeb_n++;
            if (!WEB) web_n++;
            if (rsp_valid) begin
                seen = 1'b1; rsp_cyc = cyc;
                got_we = rsp_we; got_rdata = rsp_rdata; got_last = rsp_last;
            end else begin
                tick();
                cyc++;
            end
        end
        check({tag, " rsp_seen"}, 32'(seen), 32'd1);
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!rsp_valid || rsp_rdata !== got_rdata || !CSB || CE || req_ready) stable = 1'b0;
        end
        if (stall > 0) check({tag, " stall_stable"}, 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        tick();
        check({tag, " latency"},   32'(rsp_cyc),   32'd3);
        check({tag, " acc_addr"},  32'(acc_addr),  32'(addr));
        check({tag, " acc_idata"}, 32'(acc_idata), we ? 32'(wdata) : 32'd0);
        check({tag, " ce_cycles"}, 32'(ce_n),      32'd1);
        check({tag, " web_cycles"},32'(web_n),     we ? 32'd1 : 32'd0);
        check({tag, " oeb_cycles"},32'(oeb_n),     we ? 32'd0 : 32'd2);
        check({tag, " rsp_we"},    32'(got_we),    32'(we));
        check({tag, " rsp_rdata"}, 32'(got_rdata), 32'(exp_rdata));
        check({tag, " rsp_last"},  32'(got_last),  32'd1);
        check({tag, " done_idle"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        int seen_rsp;
        RSTN = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_len = '0; rsp_ready = 1'b1; ODATA = '0;
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
        mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
        mem[16'h1234] = 8'h7E;

        // Reset values
        repeat (4) tick();
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp",  {29'd0, rsp_valid, rsp_we, rsp_last}, 32'd0);
        check("rst rdata", 32'(rsp_rdata), 32'd0);
        check("rst ADDR",  32'(ADDR), 32'd0);
        check("rst strobes", {28'd0, CE, CSB, WEB, OEB}, 32'b0111);
        check("rst IDATA", 32'(IDATA), 32'd0);
        RSTN = 1'b1;
        tick();

        run_req("wr_f658", 1'b1, 16'hF658, 8'hA5, 8'h00, 0);
        run_req("rd_f658", 1'b0, 16'hF658, 8'h00, 8'hA5, 0);
        run_req("rd_1234_stall", 1'b0, 16'h1234, 8'h00, 8'h7E, 5);
        run_req("wr_0000", 1'b1, 16'h0000, 8'h3C, 8'h00, 0);
        run_req("rd_0000", 1'b0, 16'h0000, 8'h00, 8'h3C, 0);
        mem[16'h0000] = 8'h33;

        // New request offered in the same cycle as the response handshake
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        seen_rsp = 0;
        for (int i = 0; i < 10 && seen_rsp == 0; i++) begin
            if (rsp_valid) seen_rsp = 1; else tick();
        end
        check("b2b rsp_seen", 32'(seen_rsp), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h2000; req_wdata = 8'h99;
        tick();
        check("b2b not_yet", {29'd0, CE, req_ready, rsp_valid}, 32'b010);
        tick();
        req_valid = 1'b0;
        check("b2b accepted", {29'd0, CE, WEB, req_ready}, 32'b100);
        repeat (4) tick();
        check("b2b drained", {30'd0, rsp_valid, req_ready}, 32'b01);

        // Reset during the access cycle of a write
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100; req_wdata = 8'h5A;
        tick();
        req_valid = 1'b0;
        check("rstmid in_access", 32'(CE), 32'd1);
        RSTN = 1'b0;
        tick();
        check("rstmid strobes", {29'd0, CE, CSB, WEB}, 32'b011);
        RSTN = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) seen_rsp = 1;
        end
        check("rstmid no_rsp", 32'(seen_rsp), 32'd0);
        check("rstmid req_ready", 32'(req_ready), 32'd1);

`ifdef MEMHOST_BURST_EN
        begin
            logic [15:0] addrs [4];
            logic [7:0]  rdat  [4];
            logic [3:0]  lasts;
            int n_acc, n_rsp;
            n_acc = 0; n_rsp = 0; lasts = '0;
            req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hFFFE; req_len = 8'd3; rsp_ready = 1'b1;
            tick();
            req_valid = 1'b0;
            for (int i = 0; i < 60 && n_rsp < 4; i++) begin
                if (CE && !CSB && n_acc < 4) begin addrs[n_acc] = ADDR; n_acc++; end
                if (rsp_valid) begin rdat[n_rsp] = rsp_rdata; lasts[n_rsp] = rsp_last; n_rsp++; end
                tick();
            end
            check("burst n_rsp", 32'(n_rsp), 32'd4);
            check("burst addrs", {addrs[0], addrs[1]}, 32'hFFFEFFFF);
            check("burst addrs_wrap", {addrs[2], addrs[3]}, 32'h00000001);
            check("burst rdata", {rdat[0], rdat[1], rdat[2], rdat[3]}, 32'h11223344);
            check("burst last", 32'(lasts), 32'b1000);
            tick();
            check("burst idle", {30'd0, rsp_valid, req_ready}, 32'b01);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
